atu_tune_ctrl: RTL and testbench
================================

ATU_TUNE_CTRL -- requirements
Module: atu_tune_ctrl

Interface
REQ-001 SHALL have parameter REQ_MS, default 500, meaning the start-request pulse length in ms ticks.
REQ-002 SHALL have parameter ACK_TO_MS, default 100, meaning the maximum wait for ATU ack after the request ends.
REQ-003 SHALL have parameter TUNE_TO_MS, default 4000, meaning the maximum tune duration after ack is asserted.
REQ-004 SHALL have parameter HOLD_MS, default 50, meaning the idle holdoff after any completion.
REQ-005 SHALL have input clk, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have input rst_n, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have input tick_1ms, 1 bit: single-cycle strobe, once per ms.
REQ-008 SHALL have input tune_start, 1 bit: single-cycle start command from the host control path.
REQ-009 SHALL have input tune_abort, 1 bit: single-cycle abort command.
REQ-010 SHALL have input atu_ack, 1 bit: ATU busy/key line, active high, asynchronous to clk.
REQ-011 SHALL have output atu_req, 1 bit: the ATU start request, active high; the board inverts it.
REQ-012 SHALL have output tune_tx, 1 bit: requests a low-power tune carrier from the TX path.
REQ-013 SHALL have output busy, 1 bit: high in every state except IDLE.
REQ-014 SHALL have output done, 1 bit: one-cycle pulse on completion.
REQ-015 SHALL have output result, 2 bits: 00 none, 01 success, 10 ack timeout, 11 tune timeout or abort.

Function
REQ-016 SHALL pass atu_ack through a 2-flop synchronizer (ack_s); all decisions use ack_s only.
REQ-017 SHALL implement states IDLE, REQ, WAIT_ACK, TUNE, HOLD, with a single ms counter cleared on every state entry.
REQ-018 The ms counter SHALL increment only on tick_1ms and saturate, never wrap, at 2^13-1.
REQ-019 In IDLE, tune_start SHALL enter REQ on the next cycle, clear result to 00, and assert atu_req and tune_tx.
REQ-020 In IDLE, tune_start SHALL be ignored while ack_s is high (ATU already busy); done pulses with result 10.
REQ-021 In REQ, after REQ_MS ticks, the block SHALL deassert atu_req and enter WAIT_ACK; tune_tx stays high.
REQ-022 In REQ, ack_s rising early SHALL be recorded, and REQ SHALL go to TUNE instead of WAIT_ACK at REQ_MS.
REQ-023 In WAIT_ACK, ack_s high SHALL enter TUNE; reaching ACK_TO_MS ticks SHALL end with result 10.
REQ-024 In TUNE, ack_s low SHALL end with result 01; reaching TUNE_TO_MS ticks SHALL end with result 11.
REQ-025 An "end" SHALL mean: drop tune_tx and atu_req, set result, pulse done for one cycle, then enter HOLD.
REQ-026 In HOLD, the block SHALL return to IDLE after HOLD_MS ticks; tune_start is ignored during HOLD.
REQ-027 tune_abort in REQ, WAIT_ACK or TUNE SHALL end immediately with result 11; in IDLE/HOLD it has no effect.
REQ-028 tune_abort and a success/timeout condition in the same cycle SHALL resolve as abort (result 11).
REQ-029 tune_start while busy SHALL be ignored, with no queuing.
REQ-030 result SHALL hold its value until the next accepted tune_start.

Reset
REQ-031 While rst_n is low, the block SHALL be in IDLE with atu_req=0, tune_tx=0, busy=0, done=0, result=00, counter=0, and synchronizer flops=0.
REQ-032 Reset asserted mid-operation SHALL force these values asynchronously without pulsing done; after release, the block SHALL wait for a new tune_start.

Verification
REQ-033 Nominal case: tune_start; ack rises 20 ms after atu_req falls and falls 1500 ms later -> atu_req high exactly 500 ticks, tune_tx high until ack_s falls, done pulse, result=01, busy low 50 ticks after done.
REQ-034 No-ack case: tune_start with ack held low -> atu_req 500 ticks, done at tick 600, result=10, tune_tx low.
REQ-035 Tune timeout case: ack rises and stays high -> done 4000 ticks after TUNE entry, result=11.
REQ-036 Abort case: tune_abort at tick 200 of REQ -> atu_req and tune_tx low the next cycle, done, result=11; tune_abort in the same cycle as the ack_s fall also gives result=11.
REQ-037 Ignore cases: tune_start during TUNE and during HOLD -> no state change; tune_start with ack_s high in IDLE -> result=10, no atu_req.
REQ-038 Reset case: rst_n pulsed low during TUNE -> all outputs go to reset values with no clock edge, no done pulse, and IDLE after release.

Source files
------------

// File: rtl/atu_tune_ctrl.sv
// atu_tune_ctrl: sequences an antenna tuner start request, waits for the
// tuner's busy/ack line, supervises the tune and reports the outcome.
module atu_tune_ctrl #(
  parameter int unsigned REQ_MS     = 500,
  parameter int unsigned ACK_TO_MS  = 100,
  parameter int unsigned TUNE_TO_MS = 4000,
  parameter int unsigned HOLD_MS    = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1ms,
  input  logic       tune_start,
  input  logic       tune_abort,
  input  logic       atu_ack,
  output logic       atu_req,
  output logic       tune_tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] result
);

  localparam int unsigned      CNT_W      = 13;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [1:0]       RES_NONE   = 2'b00;
  localparam logic [1:0]       RES_OK     = 2'b01;
  localparam logic [1:0]       RES_ACK_TO = 2'b10;
  localparam logic [1:0]       RES_FAIL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_TUNE,
    S_HOLD
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ack_meta_q;
  logic             ack_s_q;
  logic             early_q;
  logic             atu_req_q;
  logic             tune_tx_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       result_q;
  logic [31:0]      limit_d;
  logic             reach_d;
  logic             fin_d;
  logic [1:0]       fin_code_d;

  // Two-flop synchronizer for the asynchronous tuner busy/ack line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= atu_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Saturating ms count, per-state timeout detection and end-of-tune decode.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_1ms && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    limit_d = 32'd0;
    case (state_q)
      S_REQ:      limit_d = REQ_MS;
      S_WAIT_ACK: limit_d = ACK_TO_MS;
      S_TUNE:     limit_d = TUNE_TO_MS;
      S_HOLD:     limit_d = HOLD_MS;
      default:    limit_d = 32'd0;
    endcase
    // The tick being consumed this cycle is the one that reaches the limit.
    reach_d = tick_1ms && ((32'(cnt_q) + 32'd1) >= limit_d);

    // Abort outranks every other ending. An ack edge outranks a timeout
    // landing in the same cycle, since the tuner did answer in time.
    fin_d      = 1'b0;
    fin_code_d = RES_NONE;
    case (state_q)
      S_REQ: begin
        if (tune_abort) begin
          fin_d      = 1'b1;
          fin_code_d = RES_FAIL;
        end
      end
      S_WAIT_ACK: begin
        if (tune_abort) begin
          fin_d      = 1'b1;
          fin_code_d = RES_FAIL;
        end else if (!ack_s_q && reach_d) begin
          fin_d      = 1'b1;
          fin_code_d = RES_ACK_TO;
        end
      end
      S_TUNE: begin
        if (tune_abort) begin
          fin_d      = 1'b1;
          fin_code_d = RES_FAIL;
        end else if (!ack_s_q) begin
          fin_d      = 1'b1;
          fin_code_d = RES_OK;
        end else if (reach_d) begin
          fin_d      = 1'b1;
          fin_code_d = RES_FAIL;
        end
      end
      default: begin
        fin_d      = 1'b0;
        fin_code_d = RES_NONE;
      end
    endcase
  end

  // Control FSM with registered outputs; the ms counter restarts on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      early_q   <= 1'b0;
      atu_req_q <= 1'b0;
      tune_tx_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= RES_NONE;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_d;
      if (fin_d) begin
        state_q   <= S_HOLD;
        cnt_q     <= '0;
        early_q   <= 1'b0;
        atu_req_q <= 1'b0;
        tune_tx_q <= 1'b0;
        result_q  <= fin_code_d;
        done_q    <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (tune_start) begin
              if (ack_s_q) begin
                // Tuner already busy: refuse the start and report it.
                result_q <= RES_ACK_TO;
                done_q   <= 1'b1;
              end else begin
                state_q   <= S_REQ;
                cnt_q     <= '0;
                early_q   <= 1'b0;
                result_q  <= RES_NONE;
                atu_req_q <= 1'b1;
                tune_tx_q <= 1'b1;
                busy_q    <= 1'b1;
              end
            end
          end
          S_REQ: begin
            if (ack_s_q) begin
              early_q <= 1'b1;
            end
            if (reach_d) begin
              atu_req_q <= 1'b0;
              cnt_q     <= '0;
              state_q   <= (early_q || ack_s_q) ? S_TUNE : S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (ack_s_q) begin
              state_q <= S_TUNE;
              cnt_q   <= '0;
            end
          end
          S_TUNE: begin
            // All exits from TUNE are endings, handled above.
            state_q <= S_TUNE;
          end
          S_HOLD: begin
            if (reach_d) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign atu_req = atu_req_q;
  assign tune_tx = tune_tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_atu_tune_ctrl.sv
// tb_atu_tune_ctrl: directed and randomized tune transactions; each outcome
// is predicted in ms arithmetic and compared with what the DUT produced.
module tb_atu_tune_ctrl;

  localparam int R = 20;   // request pulse, ms
  localparam int A = 8;    // ack timeout, ms
  localparam int U = 40;   // tune timeout, ms
  localparam int H = 5;    // holdoff, ms
  localparam int P = 5;    // clocks per ms tick

  logic       clk;
  logic       rst_n;
  logic       tick_1ms;
  logic       tune_start;
  logic       tune_abort;
  logic       atu_ack;
  logic       atu_req;
  logic       tune_tx;
  logic       busy;
  logic       done;
  logic [1:0] result;

  int         phase;
  int         ticks;
  int         req_ticks;
  int         tx_ticks;
  int         busy_ticks;
  int         done_cnt;
  int         done_tick;
  logic [1:0] done_res;
  logic       ack_lvl;
  int         n_pass;
  int         n_total;

  atu_tune_ctrl #(
    .REQ_MS    (R),
    .ACK_TO_MS (A),
    .TUNE_TO_MS(U),
    .HOLD_MS   (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1ms  (tick_1ms),
    .tune_start(tune_start),
    .tune_abort(tune_abort),
    .atu_ack   (atu_ack),
    .atu_req   (atu_req),
    .tune_tx   (tune_tx),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: drive inputs just after the edge, sample outputs on the falling edge.
  task automatic cyc(input logic st, input logic ab);
    @(posedge clk);
    #1;
    phase      = (phase + 1) % P;
    tick_1ms   = (phase == 0);
    tune_start = st;
    tune_abort = ab;
    atu_ack    = ack_lvl;
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      done_tick = ticks;
      done_res  = result;
    end
    if (tick_1ms) begin
      ticks++;
      if (atu_req === 1'b1) req_ticks++;
      if (tune_tx === 1'b1) tx_ticks++;
      if (busy === 1'b1) busy_ticks++;
    end
  endtask

  task automatic clear_mon();
    ticks      = 0;
    req_ticks  = 0;
    tx_ticks   = 0;
    busy_ticks = 0;
    done_cnt   = 0;
    done_tick  = -1;
    done_res   = 2'b00;
  endtask

  // Align so that the next clock is the first one after a tick.
  task automatic sync_gap();
    while (((phase + 1) % P) != 1) cyc(1'b0, 1'b0);
  endtask

  // Ack rises after tick r and falls after tick f (ms from start); abort is
  // pulsed after tick a at clock aph of that ms. Outcome predicted up front.
  task automatic run_txn(input string nm, input bit rv, input int r, input bit fv, input int f,
                         input bit av, input int a, input int aph, input bit stray);
    int   e;
    int   nat;
    int   endms;
    int   budget;
    int   np;
    logic [1:0] code;
    logic st;
    logic ab;

    if (!rv || r >= R + A) begin
      nat  = R + A;
      code = 2'b10;
    end else begin
      e = (r < R) ? R : r;
      if (fv && f < e + U) begin
        nat  = (f > e) ? f : e;
        code = 2'b01;
      end else begin
        nat  = e + U;
        code = 2'b11;
      end
    end
    endms = nat;
    if (av && (a < nat || (a == nat && aph == 3 && code == 2'b01 && f == nat))) begin
      endms = a;
      code  = 2'b11;
    end

    ack_lvl = 1'b0;
    sync_gap();
    clear_mon();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk({nm, "/start_req"}, atu_req, 1);
    chk({nm, "/start_tx"}, tune_tx, 1);
    chk({nm, "/start_busy"}, busy, 1);
    chk({nm, "/start_result"}, result, 0);

    budget = 0;
    while (ticks <= endms + H && budget < P * (endms + H + 10)) begin
      np = (phase + 1) % P;
      st = 1'b0;
      ab = 1'b0;
      if (np == 1) ack_lvl = rv && ticks >= r && !(fv && ticks >= f);
      if (av && ticks == a && np == aph) ab = 1'b1;
      if (stray && np == 2 && ticks < endms + H && $urandom_range(0, 2) == 0) st = 1'b1;
      cyc(st, ab);
      budget++;
    end
    chk({nm, "/finished_in_budget"}, ticks > endms + H, 1);
    chk({nm, "/req_ticks"}, req_ticks, (endms < R) ? endms : R);
    chk({nm, "/tx_ticks"}, tx_ticks, endms);
    chk({nm, "/done_tick"}, done_tick, endms);
    chk({nm, "/done_result"}, done_res, code);
    chk({nm, "/busy_ticks"}, busy_ticks, endms + H);
    chk({nm, "/busy_after"}, busy, 0);

    ack_lvl = 1'b0;
    repeat (5) cyc(1'b0, 1'b0);
    chk({nm, "/done_pulses"}, done_cnt, 1);
    chk({nm, "/result_held"}, result, code);
  endtask

  initial begin
    bit rv;
    bit fv;
    bit av;
    int r;
    int f;
    int a;
    int mode;
    int budget;

    n_pass     = 0;
    n_total    = 0;
    phase      = 0;
    ack_lvl    = 1'b0;
    rst_n      = 1'b0;
    tick_1ms   = 1'b0;
    tune_start = 1'b0;
    tune_abort = 1'b0;
    atu_ack    = 1'b0;
    clear_mon();

    repeat (3) cyc(1'b0, 1'b0);
    chk("reset/atu_req", atu_req, 0);
    chk("reset/tune_tx", tune_tx, 0);
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/result", result, 0);
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b0);
    chk("idle/busy", busy, 0);

    // Directed: nominal, no ack, tune timeout, aborts, early ack, ignored starts.
    run_txn("nominal",    1, R + 4, 1, R + 34, 0, 0, 4, 0);
    run_txn("no_ack",     0, 0,     0, 0,      0, 0, 4, 0);
    run_txn("tune_to",    1, R + 2, 0, 0,      0, 0, 4, 0);
    run_txn("abort_req",  1, R + 4, 1, R + 34, 1, 8, 4, 0);
    run_txn("abort_tie",  1, R + 2, 1, R + 20, 1, R + 20, 3, 0);
    run_txn("early_fell", 1, 5,     1, 10,     0, 0, 4, 0);
    run_txn("early_held", 1, 5,     1, R + 30, 0, 0, 4, 0);
    run_txn("stray_start", 1, R + 4, 1, R + 34, 0, 0, 4, 1);
    run_txn("abort_wait", 0, 0,     0, 0,      1, R + 3, 4, 1);

    // Start while the tuner already reports busy: refused with ack timeout code.
    ack_lvl = 1'b1;
    repeat (4) cyc(1'b0, 1'b0);
    clear_mon();
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("ack_busy/done_pulses", done_cnt, 1);
    chk("ack_busy/done_result", done_res, 2'b10);
    chk("ack_busy/atu_req", atu_req, 0);
    chk("ack_busy/busy", busy, 0);
    ack_lvl = 1'b0;
    repeat (5) cyc(1'b0, 1'b0);

    // Reset pulse while tuning.
    sync_gap();
    clear_mon();
    cyc(1'b1, 1'b0);
    budget = 0;
    while (ticks < R + 5 && budget < P * (R + 20)) begin
      if (((phase + 1) % P) == 1 && ticks >= 2) ack_lvl = 1'b1;
      cyc(1'b0, 1'b0);
      budget++;
    end
    chk("rst_mid/tuning_tx", tune_tx, 1);
    chk("rst_mid/tuning_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid/async_req", atu_req, 0);
    chk("rst_mid/async_tx", tune_tx, 0);
    chk("rst_mid/async_busy", busy, 0);
    chk("rst_mid/async_done", done, 0);
    chk("rst_mid/async_result", result, 0);
    done_cnt = 0;
    ack_lvl  = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3 * P) cyc(1'b0, 1'b0);
    chk("rst_mid/no_done", done_cnt, 0);
    chk("rst_mid/idle_busy", busy, 0);
    chk("rst_mid/idle_req", atu_req, 0);
    run_txn("after_rst", 1, R + 3, 1, R + 15, 0, 0, 4, 0);

    // Randomized transactions.
    for (int i = 0; i < 25; i++) begin
      mode = $urandom_range(0, 3);
      rv   = 1;
      r    = 1;
      case (mode)
        0: r = $urandom_range(1, R - 1);
        1: r = $urandom_range(R, R + A + 2);
        2: rv = 0;
        default: r = $urandom_range(1, R + A - 1);
      endcase
      fv = ($urandom_range(0, 3) != 0);
      f  = r + $urandom_range(1, U + 5);
      av = ($urandom_range(0, 3) == 0);
      a  = $urandom_range(0, R + A + U);
      run_txn($sformatf("rnd%0d", i), rv, r, fv, f, av, a, 4, bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
